rvfpm_issue_ctrl: RTL and testbench

Issue/retire controller for the rvfpm FPU datapath. Accepts CORE-V-XIF-style issued instructions and stalls them on register hazards via a per-register busy scoreboard. Tracks instruction ids through the PIPELINE_STAGES-deep execution pipeline and arbitrates the single register-file write port between pipeline results and memory load data.

---
 rtl/rvfpm_issue_ctrl.sv | 146 ++++++++++++++
 tb/tb_rvfpm_issue_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfpm_issue_ctrl.sv
// Issue/retire controller for the rvfpm FPU: busy scoreboard, id pipeline and write-port arbitration.
// Optional macro RVFPM_FORWARD_EN lets a register cleared this cycle pass the hazard check.
module rvfpm_issue_ctrl #(
  parameter int X_ID_WIDTH      = 4,
  parameter int NUM_REGS        = 32,
  parameter int PIPELINE_STAGES = 4,
  localparam int RW = $clog2(NUM_REGS)
) (
  input  logic                                  ck,
  input  logic                                  rst,
  input  logic                                  issue_valid,
  output logic                                  issue_ready,
  input  logic [X_ID_WIDTH-1:0]                 issue_id,
  input  logic                                  issue_is_load,
  input  logic [2:0]                            issue_rs_used,
  input  logic [RW-1:0]                         issue_rs1,
  input  logic [RW-1:0]                         issue_rs2,
  input  logic [RW-1:0]                         issue_rs3,
  input  logic                                  issue_wr_freg,
  input  logic [RW-1:0]                         issue_rd,
  output logic                                  pipe_en,
  output logic [PIPELINE_STAGES-1:0]            pipe_valid,
  output logic [PIPELINE_STAGES*X_ID_WIDTH-1:0] pipe_ids,
  output logic                                  result_valid,
  input  logic                                  result_ready,
  output logic [X_ID_WIDTH-1:0]                 result_id,
  input  logic                                  ld_valid,
  input  logic [RW-1:0]                         ld_rd,
  output logic                                  ld_ready,
  output logic                                  rf_we,
  output logic [RW-1:0]                         rf_waddr,
  output logic                                  rf_wsel
);
  localparam int TAIL = PIPELINE_STAGES - 1;

  logic [PIPELINE_STAGES-1:0] stage_vld;
  logic [PIPELINE_STAGES-1:0] stage_wr;
  logic [X_ID_WIDTH-1:0]      stage_id [PIPELINE_STAGES];
  logic [RW-1:0]              stage_rd [PIPELINE_STAGES];

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_clr;
  logic [NUM_REGS-1:0] busy_set;
  logic [NUM_REGS-1:0] busy_chk;
  logic                rr;

  logic tail_valid;
  logic tail_wr;
  logic pipe_req;
  logic ld_req;
  logic pipe_grant;
  logic ld_grant;
  logic retire;
  logic pipe_wr;
  logic hazard;
  logic stage0_free;
  logic issue_fire;
  logic issue_arith;

  assign tail_valid = stage_vld[TAIL];
  assign tail_wr    = stage_wr[TAIL];

  // Write-port arbitration: rr=0 favours the pipe, rr=1 favours the load.
  assign pipe_req   = tail_valid && tail_wr;
  assign ld_req     = ld_valid && !rst;
  assign pipe_grant = pipe_req && (!ld_req || !rr);
  assign ld_grant   = ld_req && (!pipe_req || rr);

  assign result_valid = tail_valid && (!tail_wr || pipe_grant);
  assign retire       = result_valid && result_ready;
  assign pipe_wr      = pipe_grant && retire;

  assign rf_we     = pipe_wr || ld_grant;
  assign ld_ready  = ld_grant;
  assign rf_wsel   = ld_grant;
  assign rf_waddr  = ld_grant ? ld_rd : (pipe_wr ? stage_rd[TAIL] : '0);
  assign result_id = tail_valid ? stage_id[TAIL] : '0;
  assign pipe_en   = !rst && (!tail_valid || retire);

  always_comb begin
    busy_clr = '0;
    if (pipe_wr)  busy_clr[stage_rd[TAIL]] = 1'b1;
    if (ld_grant) busy_clr[ld_rd]          = 1'b1;
  end

`ifdef RVFPM_FORWARD_EN
  assign busy_chk = busy & ~busy_clr;
`else
  assign busy_chk = busy;
`endif

  assign hazard = (issue_rs_used[0] && busy_chk[issue_rs1]) ||
                  (issue_rs_used[1] && busy_chk[issue_rs2]) ||
                  (issue_rs_used[2] && busy_chk[issue_rs3]) ||
                  ((issue_is_load || issue_wr_freg) && busy_chk[issue_rd]);

  assign stage0_free = pipe_en || !stage_vld[0];
  assign issue_ready = !rst && !hazard && (issue_is_load || stage0_free);
  assign issue_fire  = issue_valid && issue_ready;
  assign issue_arith = issue_fire && !issue_is_load;

  always_comb begin
    busy_set = '0;
    if (issue_fire && (issue_is_load || issue_wr_freg)) busy_set[issue_rd] = 1'b1;
  end

  // Control state: valids, scoreboard (set wins over clear), rr pointer.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      stage_vld <= '0;
      busy      <= '0;
      rr        <= 1'b0;
    end else begin
      busy <= (busy & ~busy_clr) | busy_set;
      if (pipe_req && ld_req && rf_we) rr <= ~rr;
      if (pipe_en) begin
        for (int i = TAIL; i > 0; i--) stage_vld[i] <= stage_vld[i-1];
        stage_vld[0] <= issue_arith;
      end else if (issue_arith) begin
        stage_vld[0] <= 1'b1;
      end
    end
  end

  // Stage payload; only meaningful where the matching valid is set.
  always_ff @(posedge ck) begin
    if (pipe_en) begin
      for (int i = TAIL; i > 0; i--) begin
        stage_id[i] <= stage_id[i-1];
        stage_rd[i] <= stage_rd[i-1];
        stage_wr[i] <= stage_wr[i-1];
      end
    end
    if (stage0_free) begin
      stage_id[0] <= issue_id;
      stage_rd[0] <= issue_rd;
      stage_wr[0] <= issue_wr_freg;
    end
  end

  assign pipe_valid = stage_vld;

  for (genvar g = 0; g < PIPELINE_STAGES; g++) begin : g_ids
    assign pipe_ids[g*X_ID_WIDTH +: X_ID_WIDTH] = stage_id[g];
  end
endmodule

// File: tb/tb_rvfpm_issue_ctrl.sv
// Bench for rvfpm_issue_ctrl: directed scenarios plus random traffic against a cycle model.
module tb_rvfpm_issue_ctrl;
  localparam int XW = 4;
  localparam int NR = 32;
  localparam int PS = 4;
  localparam int RW = 5;
  localparam int T  = PS - 1;
`ifdef RVFPM_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic ck = 1'b0;
  logic rst = 1'b1;
  logic issue_valid, issue_ready, issue_is_load, issue_wr_freg;
  logic [XW-1:0] issue_id;
  logic [2:0] issue_rs_used;
  logic [RW-1:0] issue_rs1, issue_rs2, issue_rs3, issue_rd;
  logic pipe_en;
  logic [PS-1:0] pipe_valid;
  logic [PS*XW-1:0] pipe_ids;
  logic result_valid, result_ready;
  logic [XW-1:0] result_id;
  logic ld_valid, ld_ready, rf_we, rf_wsel;
  logic [RW-1:0] ld_rd, rf_waddr;

  always #5 ck = ~ck;

  rvfpm_issue_ctrl #(.X_ID_WIDTH(XW), .NUM_REGS(NR), .PIPELINE_STAGES(PS)) dut (
    .ck(ck), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_id(issue_id),
    .issue_is_load(issue_is_load), .issue_rs_used(issue_rs_used),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rs3(issue_rs3),
    .issue_wr_freg(issue_wr_freg), .issue_rd(issue_rd),
    .pipe_en(pipe_en), .pipe_valid(pipe_valid), .pipe_ids(pipe_ids),
    .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_ready(ld_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wsel(rf_wsel)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference state: in-flight slots, scoreboard, rr pointer, outstanding loads.
  bit mv [PS];
  int mid [PS];
  int mrd [PS];
  bit mwr [PS];
  bit mbusy [NR];
  bit mrr;
  int pend [$];
  bit f_fire, f_pw, f_lg, f_adv, f_cont;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < PS; i++) begin
      mv[i] = 0; mid[i] = 0; mrd[i] = 0; mwr[i] = 0;
    end
    for (int r = 0; r < NR; r++) mbusy[r] = 0;
    mrr = 0;
    pend.delete();
  endtask

  function automatic bit busy_seen(int r, bit pw, int trd, bit lg);
    return mbusy[r] && !(FWD && ((pw && r == trd) || (lg && r == int'(ld_rd))));
  endfunction

  task automatic settle_check();
    bit pq, lq, pg, lg, rv, ret, pw, we, adv, haz, rdy;
    int trd;
    logic [PS-1:0] pv;
    #1;
    if (rst) begin
      model_clear();
      f_fire = 0; f_pw = 0; f_lg = 0; f_adv = 0; f_cont = 0;
      chk("rst_issue_ready", 32'(issue_ready), 0);
      chk("rst_pipe_en", 32'(pipe_en), 0);
      chk("rst_result_valid", 32'(result_valid), 0);
      chk("rst_ld_ready", 32'(ld_ready), 0);
      chk("rst_rf_we", 32'(rf_we), 0);
      chk("rst_rf_waddr", 32'(rf_waddr), 0);
      chk("rst_rf_wsel", 32'(rf_wsel), 0);
      chk("rst_result_id", 32'(result_id), 0);
      chk("rst_pipe_valid", 32'(pipe_valid), 0);
      return;
    end
    trd = mrd[T];
    pq = mv[T] && mwr[T];
    lq = ld_valid;
    if (pq && lq) begin pg = !mrr; lg = mrr; end
    else begin pg = pq; lg = lq; end
    rv  = mv[T] && (!mwr[T] || pg);
    ret = rv && result_ready;
    pw  = pg && ret;
    we  = pw || lg;
    adv = !mv[T] || ret;
    haz = (issue_rs_used[0] && busy_seen(int'(issue_rs1), pw, trd, lg)) ||
          (issue_rs_used[1] && busy_seen(int'(issue_rs2), pw, trd, lg)) ||
          (issue_rs_used[2] && busy_seen(int'(issue_rs3), pw, trd, lg)) ||
          ((issue_is_load || issue_wr_freg) && busy_seen(int'(issue_rd), pw, trd, lg));
    rdy = !haz && (issue_is_load || adv || !mv[0]);
    for (int i = 0; i < PS; i++) pv[i] = mv[i];
    chk("issue_ready", 32'(issue_ready), 32'(rdy));
    chk("pipe_en", 32'(pipe_en), 32'(adv));
    chk("pipe_valid", 32'(pipe_valid), 32'(pv));
    chk("result_valid", 32'(result_valid), 32'(rv));
    chk("ld_ready", 32'(ld_ready), 32'(lg));
    chk("rf_we", 32'(rf_we), 32'(we));
    if (rv) chk("result_id", 32'(result_id), mid[T]);
    if (we) begin
      chk("rf_wsel", 32'(rf_wsel), 32'(lg));
      chk("rf_waddr", 32'(rf_waddr), lg ? int'(ld_rd) : trd);
    end
    f_fire = issue_valid && rdy;
    f_pw = pw; f_lg = lg; f_adv = adv; f_cont = pq && lq;
  endtask

  task automatic advance();
    @(posedge ck);
    if (rst) model_clear();
    else begin
      if (f_pw) mbusy[mrd[T]] = 0;
      if (f_lg) begin
        mbusy[ld_rd] = 0;
        foreach (pend[k]) if (pend[k] == int'(ld_rd)) begin pend.delete(k); break; end
      end
      if (f_fire && (issue_is_load || issue_wr_freg)) mbusy[issue_rd] = 1;
      if (f_fire && issue_is_load) pend.push_back(int'(issue_rd));
      if (f_cont && (f_lg || f_pw)) mrr = !mrr;
      if (f_adv || (f_fire && !issue_is_load)) begin
        if (f_adv)
          for (int i = T; i > 0; i--) begin
            mv[i] = mv[i-1]; mid[i] = mid[i-1]; mrd[i] = mrd[i-1]; mwr[i] = mwr[i-1];
          end
        mv[0]  = f_fire && !issue_is_load;
        mid[0] = int'(issue_id);
        mrd[0] = int'(issue_rd);
        mwr[0] = issue_wr_freg;
      end
    end
    @(negedge ck);
  endtask

  task automatic idle();
    issue_valid = 0; issue_id = '0; issue_is_load = 0; issue_rs_used = '0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rs3 = '0; issue_wr_freg = 0; issue_rd = '0;
    result_ready = 1; ld_valid = 0; ld_rd = '0;
  endtask

  task automatic drv_issue(input int id, input int rd, input bit wr, input bit ld,
                           input logic [2:0] used, input int rs1);
    issue_valid = 1; issue_id = XW'(id); issue_rd = RW'(rd); issue_wr_freg = wr;
    issue_is_load = ld; issue_rs_used = used; issue_rs1 = RW'(rs1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [PS*XW-1:0] snap;
    model_clear();
    idle();
    @(negedge ck);
    settle_check(); advance();
    settle_check(); advance();
    rst = 0;
    settle_check();
    chk("first_ready", 32'(issue_ready), 1);
    advance();

    // Independent stream, no stalls.
    for (int c = 0; c < 10; c++) begin
      idle();
      if (c < 4) drv_issue(c + 1, c + 1, 1, 0, 3'b000, 0);
      settle_check();
      if (c < 4) chk("stream_ready", 32'(issue_ready), 1);
      if (c >= 4 && c < 8) begin
        chk("stream_rv", 32'(result_valid), 1);
        chk("stream_id", 32'(result_id), c - 3);
        chk("stream_waddr", 32'(rf_waddr), c - 3);
      end
      advance();
    end

    // Reset while three instructions are in flight.
    for (int c = 0; c < 3; c++) begin
      idle();
      drv_issue(5 + c, (c == 0) ? 5 : 6 + c, 1, 0, 3'b000, 0);
      settle_check(); advance();
    end
    idle(); rst = 1;
    settle_check();
    chk("midrst_pipe_valid", 32'(pipe_valid), 0);
    advance();
    rst = 0;
    drv_issue(9, 5, 1, 0, 3'b001, 6);
    settle_check();
    chk("midrst_ready_after", 32'(issue_ready), 1);
    advance();
    for (int c = 0; c < 6; c++) begin idle(); settle_check(); advance(); end

    // RAW on f3.
    acc = -1;
    for (int c = 0; c < 20; c++) begin
      idle();
      if (c == 0) drv_issue(1, 3, 1, 0, 3'b000, 0);
      else if (acc < 0) drv_issue(2, 10, 1, 0, 3'b001, 3);
      settle_check();
      if (c > 0 && acc < 0 && issue_ready) acc = c;
      advance();
    end
    chk("raw_accept_cycle", acc, FWD ? 4 : 5);

    // Backpressure with a full pipe.
    for (int c = 0; c < 17; c++) begin
      idle();
      if (c < 4) begin drv_issue(c + 1, 11 + c, 1, 0, 3'b000, 0); result_ready = 0; end
      else if (c < 9) begin drv_issue(5, 15, 1, 0, 3'b000, 0); result_ready = 0; end
      settle_check();
      if (c == 4) begin
        snap = pipe_ids;
        chk("bp_full", 32'(pipe_valid), 32'((1 << PS) - 1));
      end
      if (c >= 4 && c < 9) begin
        chk("bp_pipe_en", 32'(pipe_en), 0);
        chk("bp_ready", 32'(issue_ready), 0);
        if (c > 4) chk("bp_ids_frozen", 32'(pipe_ids), 32'(snap));
      end
      if (c >= 9 && c < 13) chk("bp_drain_id", 32'(result_id), c - 8);
      advance();
    end

    // Write-port contention: tail writes vs load to f9.
    for (int c = 0; c < 11; c++) begin
      idle();
      if (c < 3) drv_issue(c + 1, 20 + c, 1, 0, 3'b000, 0);
      if (c >= 4 && c < 7) begin ld_valid = 1; ld_rd = RW'(9); end
      settle_check();
      if (c >= 4 && c < 8) chk("cont_we", 32'(rf_we), 1);
      if (c == 4) begin chk("cont_sel0", 32'(rf_wsel), 0); chk("cont_addr0", 32'(rf_waddr), 20); end
      if (c == 5) begin chk("cont_sel1", 32'(rf_wsel), 1); chk("cont_addr1", 32'(rf_waddr), 9); end
      if (c == 6) begin chk("cont_sel2", 32'(rf_wsel), 0); chk("cont_addr2", 32'(rf_waddr), 21); end
      if (c == 7) chk("cont_addr3", 32'(rf_waddr), 22);
      advance();
    end

    // Load WAW on f2.
    acc = -1;
    for (int c = 0; c < 12; c++) begin
      idle();
      if (c == 0) drv_issue(1, 2, 0, 1, 3'b000, 0);
      else if (acc < 0) drv_issue(2, 2, 1, 0, 3'b000, 0);
      if (c == 3) begin ld_valid = 1; ld_rd = RW'(2); end
      settle_check();
      if (c == 3) chk("ldwaw_ld_ready", 32'(ld_ready), 1);
      if (c > 0 && acc < 0 && issue_ready) acc = c;
      advance();
    end
    chk("ldwaw_accept_cycle", acc, FWD ? 3 : 4);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      issue_valid   = ($urandom % 4) != 0;
      issue_id      = XW'($urandom);
      issue_is_load = ($urandom % 5) == 0;
      issue_rs_used = 3'($urandom);
      issue_rs1     = RW'($urandom_range(0, 7));
      issue_rs2     = RW'($urandom_range(0, 7));
      issue_rs3     = RW'($urandom_range(0, 7));
      issue_rd      = RW'($urandom_range(0, 7));
      issue_wr_freg = ($urandom % 4) != 0;
      result_ready  = ($urandom % 4) != 0;
      ld_valid = 0; ld_rd = '0;
      if (pend.size() > 0 && ($urandom % 3) == 0) begin
        ld_valid = 1; ld_rd = RW'(pend[0]);
      end else if (($urandom % 10) == 0) begin
        ld_valid = 1; ld_rd = RW'($urandom_range(0, 7));
      end
      settle_check();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
